// File: rtl/stream_gearbox.sv
// Valid/ready width converter between IN_WIDTH and OUT_WIDTH bit words, any ratio,
// with end-of-packet zero padding. Define STREAM_GEARBOX_PAD_CNT_EN to add pad_bits.
module stream_gearbox #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
`ifdef STREAM_GEARBOX_PAD_CNT_EN
  output logic [$clog2(OUT_WIDTH+1)-1:0] pad_bits,
`endif
  input  logic                 out_ready
);
  localparam int BUF = IN_WIDTH + OUT_WIDTH;
  localparam int FW  = $clog2(BUF + 1);
  localparam logic [FW-1:0] OW_F  = FW'(OUT_WIDTH);
  localparam logic [FW-1:0] IW_F  = FW'(IN_WIDTH);
  localparam logic [FW:0]   BUF_F = (FW+1)'(BUF);

  // Buffer is kept in stream order: oldest bit at the MSB, unused tail always zero.
  logic [BUF-1:0]       buf_q, buf_d;
  logic [FW-1:0]        fill_q, fill_d, fill_after;
  logic                 last_pending_q, last_pending_d;
  logic [IN_WIDTH-1:0]  in_word;
  logic [OUT_WIDTH-1:0] head;
  logic                 out_fire, in_fire;

  always_comb begin
    in_word = '0;
    for (int i = 0; i < IN_WIDTH; i++)
      in_word[IN_WIDTH-1-i] = (MSB_FIRST != 0) ? in_data[IN_WIDTH-1-i] : in_data[i];
  end

  assign head = buf_q[BUF-1 -: OUT_WIDTH];

  always_comb begin
    out_data = '0;
    for (int i = 0; i < OUT_WIDTH; i++)
      out_data[i] = (MSB_FIRST != 0) ? head[i] : head[OUT_WIDTH-1-i];
  end

  assign out_valid  = (fill_q >= OW_F) || (last_pending_q && fill_q != '0);
  assign out_last   = last_pending_q && (fill_q <= OW_F) && (fill_q != '0);
  assign out_fire   = out_valid && out_ready;
  assign fill_after = !out_fire ? fill_q : (fill_q >= OW_F) ? fill_q - OW_F : '0;
  // Combinational from out_ready so a drained slot can be refilled on the same edge.
  assign in_ready   = !rst && !last_pending_q && ({1'b0, fill_after} + {1'b0, IW_F} <= BUF_F);
  assign in_fire    = in_valid && in_ready;

`ifdef STREAM_GEARBOX_PAD_CNT_EN
  localparam int PW = $clog2(OUT_WIDTH + 1);
  logic [FW-1:0] pad_full;
  assign pad_full = OW_F - fill_q;
  assign pad_bits = out_last ? pad_full[PW-1:0] : '0;
`endif

  always_comb begin
    buf_d          = buf_q;
    fill_d         = fill_after;
    last_pending_d = last_pending_q;
    if (out_fire) buf_d = buf_q << OUT_WIDTH;
    if (out_fire && out_last) begin
      buf_d          = '0;
      fill_d         = '0;
      last_pending_d = 1'b0;
    end else if (in_fire) begin
      buf_d          = buf_d | ({in_word, {OUT_WIDTH{1'b0}}} >> fill_after);
      fill_d         = fill_after + IW_F;
      last_pending_d = in_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q          <= '0;
      fill_q         <= '0;
      last_pending_q <= 1'b0;
    end else begin
      buf_q          <= buf_d;
      fill_q         <= fill_d;
      last_pending_q <= last_pending_d;
    end
  end
endmodule

// File: tb/tb_stream_gearbox.sv
// Bench for stream_gearbox: four width/order configurations, each checked every
// cycle against a bit-queue model, plus literal beat sequences for known inputs.
module tb_stream_gearbox;
  localparam int NI = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int IW   = (g == 1) ? 1 : 8;
    localparam int OW   = (g == 0) ? 1 : (g == 1) ? 8 : (g == 2) ? 3 : 4;
    localparam int MF   = (g == 3) ? 0 : 1;
    localparam int BUFW = IW + OW;
    localparam int PW   = $clog2(OW + 1);

    logic rst = 1'b1, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, out_last;
    logic [IW-1:0] in_data = '0;
    logic [OW-1:0] out_data;
`ifdef STREAM_GEARBOX_PAD_CNT_EN
    logic [PW-1:0] pad_bits;
`endif
    logic [IW-1:0] sd[$];
    bit            sl[$];
    bit            q[$];
    bit            lp = 1'b0;
    int            vprob = 100, rprob = 100;
    logic [OW-1:0] bd[$];
    bit            bl[$];
    int            bc[$];
    bit            fin = 1'b0;
    bit            ofire, ifire;

    stream_gearbox #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .MSB_FIRST(MF)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
`ifdef STREAM_GEARBOX_PAD_CNT_EN
      .pad_bits(pad_bits),
`endif
      .out_ready(out_ready));

    function automatic logic exp_valid();
      return (q.size() >= OW) || (lp && q.size() > 0);
    endfunction
    function automatic logic exp_last();
      return lp && q.size() > 0 && q.size() <= OW;
    endfunction
    function automatic logic [OW-1:0] exp_data();
      logic [OW-1:0] r = '0;
      for (int k = 0; k < OW && k < q.size(); k++) r[MF ? OW-1-k : k] = q[k];
      return r;
    endfunction
    function automatic logic exp_ready();
      int pop = (exp_valid() && out_ready) ? ((q.size() < OW) ? q.size() : OW) : 0;
      return !rst && !lp && (q.size() - pop + IW <= BUFW);
    endfunction

    // Model update on the edge, then drive the next cycle's inputs.
    always @(posedge clk) begin
      ofire = exp_valid() && out_ready;
      ifire = in_valid && exp_ready();
      if (rst) begin
        q.delete();
        lp = 1'b0;
      end else begin
        if (out_valid && out_ready) begin
          bd.push_back(out_data); bl.push_back(out_last); bc.push_back(cyc);
        end
        if (ofire) begin
          if (exp_last()) begin q.delete(); lp = 1'b0; end
          else for (int k = 0; k < OW; k++) void'(q.pop_front());
        end
        if (ifire) begin
          for (int k = 0; k < IW; k++) q.push_back(MF ? sd[0][IW-1-k] : sd[0][k]);
          lp = sl[0];
          void'(sd.pop_front()); void'(sl.pop_front());
        end
      end
      #1;
      in_valid  = (sd.size() > 0) && ($urandom_range(99) < vprob);
      in_data   = (sd.size() > 0) ? sd[0] : '0;
      in_last   = (sl.size() > 0) ? sl[0] : 1'b0;
      out_ready = $urandom_range(99) < rprob;
    end

    always @(negedge clk) begin
      chk($sformatf("g%0d_out_valid", g), 64'(out_valid), 64'(exp_valid()));
      chk($sformatf("g%0d_in_ready", g), 64'(in_ready), 64'(exp_ready()));
      if (exp_valid() || q.size() == 0)
        chk($sformatf("g%0d_out_data", g), 64'(out_data), 64'(exp_data()));
      if (exp_valid()) begin
        chk($sformatf("g%0d_out_last", g), 64'(out_last), 64'(exp_last()));
`ifdef STREAM_GEARBOX_PAD_CNT_EN
        chk($sformatf("g%0d_pad_bits", g), 64'(pad_bits),
            exp_last() ? 64'(OW - q.size()) : 64'd0);
`endif
      end
    end

    task automatic start();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
    endtask
    task automatic push(input logic [IW-1:0] d, input bit l);
      sd.push_back(d); sl.push_back(l);
    endtask
    task automatic clear_rec();
      bd.delete(); bl.delete(); bc.delete();
    endtask
    task automatic drain(input string nm);
      int t = 0;
      while ((sd.size() > 0 || q.size() > 0 || lp) && t < 3000) begin
        @(posedge clk); #2; t++;
      end
      chk($sformatf("g%0d_%s_drained", g, nm), 64'(t < 3000), 64'd1);
    endtask
    task automatic random_phase();
      clear_rec();
      vprob = 70; rprob = 50;
      for (int k = 0; k < 40; k++) push(IW'($urandom), ($urandom_range(4) == 0) || k == 39);
      drain("random");
      chk($sformatf("g%0d_random_beats_seen", g), 64'(bd.size() > 0), 64'd1);
      vprob = 100; rprob = 100;
    endtask

    if (g == 0) begin : d0
      initial begin
        logic [7:0] a5, c3;
        int t;
        a5 = 8'hA5; c3 = 8'h3C;
        start(); clear_rec();
        push(8'hA5, 1'b0); push(8'hA5, 1'b0);
        drain("a5x2");
        chk("g0_beats", 64'(bd.size()), 64'd16);
        for (int k = 0; k < 16; k++) chk($sformatf("g0_bit%0d", k), 64'(bd[k]), 64'(a5[7-(k%8)]));
        chk("g0_no_bubble", 64'(bc[15] - bc[0]), 64'd15);
        clear_rec();
        push(8'hA5, 1'b0);
        t = 0;
        while (bd.size() < 2 && t < 100) begin @(posedge clk); #2; t++; end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("g0_valid_after_rst", 64'(out_valid), 64'd0);
        chk("g0_beats_before_rst", 64'(bd.size()), 64'd2);
        chk("g0_pre_rst_b0", 64'(bd[0]), 64'd1);
        chk("g0_pre_rst_b1", 64'(bd[1]), 64'd0);
        clear_rec();
        push(8'h3C, 1'b0);
        drain("3c");
        chk("g0_3c_beats", 64'(bd.size()), 64'd8);
        for (int k = 0; k < 8; k++) chk($sformatf("g0_3c_bit%0d", k), 64'(bd[k]), 64'(c3[7-k]));
        random_phase();
        fin = 1'b1;
      end
    end else if (g == 1) begin : d1
      initial begin
        logic [15:0] bits;
        bits = 16'hA55A;
        start(); clear_rec();
        for (int k = 15; k >= 0; k--) push(IW'(bits[k]), 1'b0);
        drain("bits");
        chk("g1_beats", 64'(bd.size()), 64'd2);
        chk("g1_beat0", 64'(bd[0]), 64'hA5);
        chk("g1_beat1", 64'(bd[1]), 64'h5A);
        chk("g1_spacing", 64'(bc[1] - bc[0]), 64'd8);
        random_phase();
        fin = 1'b1;
      end
    end else if (g == 2) begin : d2
      initial begin
        logic [OW-1:0] exp_b[6];
        exp_b = '{3'd5, 3'd1, 3'd2, 3'd3, 3'd6, 3'd0};
        start(); clear_rec();
        push(8'hA5, 1'b0); push(8'h3C, 1'b1);
        drain("pkt");
        chk("g2_beats", 64'(bd.size()), 64'd6);
        for (int k = 0; k < 6; k++) begin
          chk($sformatf("g2_beat%0d", k), 64'(bd[k]), 64'(exp_b[k]));
          chk($sformatf("g2_last%0d", k), 64'(bl[k]), 64'(k == 5));
        end
        random_phase();
        fin = 1'b1;
      end
    end else begin : d3
      initial begin
        start(); clear_rec();
        push(8'hA5, 1'b0);
        drain("lsb");
        chk("g3_beats", 64'(bd.size()), 64'd2);
        chk("g3_beat0", 64'(bd[0]), 64'h5);
        chk("g3_beat1", 64'(bd[1]), 64'hA);
        random_phase();
        fin = 1'b1;
      end
    end
  end

  initial begin
    fork
      wait (gi[0].fin && gi[1].fin && gi[2].fin && gi[3].fin);
      begin
        repeat (60000) @(posedge clk);
        errors++;
        $display("FAIL timeout actual=unfinished required=finished");
      end
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
